// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter, with NAK re-send and ACK timeout
module uart_tx_sched #(
   parameter int N_REQ     = 4,
   parameter int MAX_RETRY = 3,
   parameter int ACK_WIN   = 64
) (
   input  logic               clk,
   input  logic               areset_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_par,
   output logic [N_REQ-1:0]   ack,
   output logic [7:0]         tx_data,
   output logic               tx_empty,
   output logic               tx_strt,
   output logic               tx_par,
   output logic               tx_fb,
   input  logic               tx_rd,
   input  logic               tx_busy,
   input  logic               rx_ack,
   input  logic               rx_nak,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [2:0]         src_id
);
   typedef enum logic [2:0] {IDLE, ARM, SEND, CHECK, RETRY} state_t;
   state_t state, state_d;
   logic [2:0] last_gnt, last_gnt_d, gnt, src_id_d;
   logic [3:0] retry_cnt, retry_cnt_d;
   logic [7:0] timer, timer_d, sel_data, tx_data_d;
   logic [N_REQ-1:0] ack_d;
   logic [1:0] err_code_d;
   logic busy_q, any_req, sel_par, tx_empty_d, tx_strt_d, tx_par_d, tx_fb_d, done_d, err_d;
   // lowest requester overall is the wrap-around choice; lowest above last_gnt overrides it
   always_comb begin
      gnt = '0;
      sel_data = '0;
      sel_par = 1'b0;
      any_req = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[i]) begin
            gnt = 3'(i);
            sel_data = req_data[8*i +: 8];
            sel_par = req_par[i];
            any_req = 1'b1;
         end
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[i] && 3'(i) > last_gnt) begin
            gnt = 3'(i);
            sel_data = req_data[8*i +: 8];
            sel_par = req_par[i];
         end
   end
   always_comb begin
      state_d = state;
      last_gnt_d = last_gnt;
      retry_cnt_d = retry_cnt;
      timer_d = timer;
      tx_data_d = tx_data;
      tx_par_d = tx_par;
      tx_empty_d = tx_empty;
      tx_strt_d = tx_strt;
      tx_fb_d = tx_fb;
      ack_d = '0;
      done_d = 1'b0;
      err_d = 1'b0;
      err_code_d = err_code;
      src_id_d = src_id;
      case (state)
         IDLE:
            if (any_req) begin
               state_d = ARM;
               last_gnt_d = gnt;
               retry_cnt_d = '0;
               tx_data_d = sel_data;
               tx_par_d = sel_par;
               tx_empty_d = 1'b0;
               tx_strt_d = 1'b1;
               ack_d = {{(N_REQ-1){1'b0}}, 1'b1} << gnt;
               src_id_d = gnt;
            end
         ARM:
            if (tx_rd) begin
               tx_strt_d = 1'b0;
               tx_empty_d = 1'b1;
               state_d = SEND;
            end
         SEND:
            if (busy_q && !tx_busy) begin
               timer_d = 8'(ACK_WIN);
               state_d = CHECK;
            end
         CHECK: begin
            timer_d = timer - 8'd1;
            if (rx_nak && retry_cnt < 4'(MAX_RETRY)) begin
               retry_cnt_d = retry_cnt + 4'd1;
               tx_fb_d = 1'b1;
               state_d = RETRY;
            end else if (rx_nak || (!rx_ack && timer == 8'd1)) begin
               err_d = 1'b1;
               err_code_d = rx_nak ? 2'b01 : 2'b10;
               state_d = IDLE;
            end else if (rx_ack) begin
               done_d = 1'b1;
               state_d = IDLE;
            end
         end
         RETRY:
            if (!busy_q && tx_busy) begin
               tx_fb_d = 1'b0;
               state_d = SEND;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge areset_n)
      if (!areset_n) begin
         state <= IDLE;
         last_gnt <= 3'(N_REQ - 1);
         retry_cnt <= '0;
         timer <= '0;
         busy_q <= 1'b0;
         tx_data <= '0;
         tx_par <= 1'b0;
         tx_empty <= 1'b1;
         tx_strt <= 1'b0;
         tx_fb <= 1'b0;
         ack <= '0;
         done <= 1'b0;
         err <= 1'b0;
         err_code <= '0;
         src_id <= '0;
      end else begin
         state <= state_d;
         last_gnt <= last_gnt_d;
         retry_cnt <= retry_cnt_d;
         timer <= timer_d;
         busy_q <= tx_busy;
         tx_data <= tx_data_d;
         tx_par <= tx_par_d;
         tx_empty <= tx_empty_d;
         tx_strt <= tx_strt_d;
         tx_fb <= tx_fb_d;
         ack <= ack_d;
         done <= done_d;
         err <= err_d;
         err_code <= err_code_d;
         src_id <= src_id_d;
      end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: bench plays transmitter and receiver, predicting grants and outcomes per frame
module tb_uart_tx_sched;
   localparam int N = 4, MR = 3, AW = 64;
   localparam logic [1:0] R_ACK = 2'd0, R_NAK = 2'd1, R_BOTH = 2'd2, R_NONE = 2'd3;
   logic clk = 1'b0, areset_n = 1'b1;
   logic [N-1:0] req = '0, req_par = '0, ack;
   logic [8*N-1:0] req_data = '0;
   logic [7:0] tx_data;
   logic tx_empty, tx_strt, tx_par, tx_fb, done, err;
   logic tx_rd = 1'b0, tx_busy = 1'b0, rx_ack = 1'b0, rx_nak = 1'b0;
   logic [1:0] err_code;
   logic [2:0] src_id;
   int n_chk = 0, n_pass = 0, rr_last = N - 1;

   always #5 clk = ~clk;

   uart_tx_sched #(.N_REQ(N), .MAX_RETRY(MR), .ACK_WIN(AW)) dut (
      .clk(clk), .areset_n(areset_n), .req(req), .req_data(req_data), .req_par(req_par),
      .ack(ack), .tx_data(tx_data), .tx_empty(tx_empty), .tx_strt(tx_strt), .tx_par(tx_par),
      .tx_fb(tx_fb), .tx_rd(tx_rd), .tx_busy(tx_busy), .rx_ack(rx_ack), .rx_nak(rx_nak),
      .done(done), .err(err), .err_code(err_code), .src_id(src_id)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // round-robin reference: first requester found walking upward from the last grant
   function automatic int pick(input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (((r >> ((rr_last + k) % N)) & 1) != 0) return (rr_last + k) % N;
      return -1;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_outs"}, {ack, tx_data, tx_strt, tx_par, tx_fb, done, err, err_code, src_id}, 0);
      chk({tag, "_empty"}, tx_empty, 1);
   endtask

   // rs holds one response code per attempt, attempt 0 in the low bits
   task automatic frame(input logic [N-1:0] r, input logic [8*N-1:0] d, input logic [N-1:0] p,
                        input logic [9:0] rs, input int dly, input bit hold);
      int g, att, w;
      logic [1:0] code;
      g = pick(r);
      req = r; req_data = d; req_par = p;
      tick();
      chk("ack", ack, 1 << g);
      chk("src_grant", src_id, g);
      chk("strt", tx_strt, 1);
      chk("empty_arm", tx_empty, 0);
      chk("data", tx_data, 8'(d >> (8 * g)));
      chk("par", tx_par, (p >> g) & 1);
      chk("prev_pulse", done | err, 0);
      rr_last = g;
      if (!hold) req = '0;
      repeat ($urandom_range(1, 3)) begin
         tick();
         chk("ack_pulse", ack, 0);
         chk("strt_hold", tx_strt, 1);
      end
      tx_rd = 1'b1;
      tick();
      tx_rd = 1'b0;
      chk("strt_clr", tx_strt, 0);
      chk("empty_set", tx_empty, 1);
      att = 0;
      forever begin
         code = 2'(rs >> (2 * att));
         tx_busy = 1'b1;
         repeat ($urandom_range(2, 8)) begin
            rx_ack = 1'($urandom);
            rx_nak = 1'($urandom);
            tick();
            chk("fb_low_busy", tx_fb, 0);
            chk("quiet_busy", done | err, 0);
         end
         rx_ack = 1'b0; rx_nak = 1'b0; tx_busy = 1'b0;
         tick();
         if (code == R_NONE) begin
            repeat (AW - 1) begin
               tick();
               chk("no_early_to", done | err, 0);
            end
            tick();
            chk("to_err", err, 1);
            chk("to_code", err_code, 2);
            chk("to_src", src_id, g);
            break;
         end
         w = (dly > 0) ? dly : $urandom_range(1, AW);
         repeat (w - 1) begin
            tick();
            chk("wait_quiet", done | err, 0);
         end
         rx_ack = code != R_NAK;
         rx_nak = code != R_ACK;
         tick();
         rx_ack = 1'b0; rx_nak = 1'b0;
         if (code == R_ACK) begin
            chk("done", done, 1);
            chk("done_noerr", err, 0);
            chk("done_src", src_id, g);
            chk("done_fb", tx_fb, 0);
            break;
         end
         if (att == MR) begin
            chk("lim_err", err, 1);
            chk("lim_code", err_code, 1);
            chk("lim_nodone", done, 0);
            chk("lim_src", src_id, g);
            chk("lim_fb", tx_fb, 0);
            break;
         end
         chk("retry_fb", tx_fb, 1);
         chk("retry_empty", tx_empty, 1);
         chk("retry_quiet", done | err, 0);
         att++;
         repeat ($urandom_range(0, 3)) begin
            tick();
            chk("fb_hold", tx_fb, 1);
            chk("retry_strt", tx_strt, 0);
         end
      end
      if (!hold)
         repeat (2) begin
            tick();
            chk("idle_fb", tx_fb, 0);
            chk("idle_empty", tx_empty, 1);
            chk("idle_quiet", {done, err, ack, tx_strt}, 0);
         end
   endtask

   task automatic reset_mid_send();
      int g;
      g = pick(4'b0100);
      req = 4'b0100; req_data = $urandom; req_par = '1;
      tick();
      chk("rst_gnt", ack, 1 << g);
      req = '0;
      tx_rd = 1'b1;
      tick();
      tx_rd = 1'b0;
      tx_busy = 1'b1;
      repeat (3) tick();
      #2 areset_n = 1'b0;
      #1 chk_reset("rst_async");
      tx_busy = 1'b0;
      rr_last = N - 1;
      tick();
      chk_reset("rst_held");
      areset_n = 1'b1;
   endtask

   initial begin
      logic [9:0] rs;
      int x;
      #2 areset_n = 1'b0;
      #1 chk_reset("por");
      tick();
      tick();
      areset_n = 1'b1;
      frame(4'b0001, 32'h0000_00a5, 4'b0001, {8'd0, R_ACK}, 5, 1'b0);
      reset_mid_send();
      for (int i = 0; i < 5; i++) frame('1, $urandom, 4'(i + 5), {8'd0, R_ACK}, 0, i < 4);
      frame(4'b0010, $urandom, '1, {6'd0, R_ACK, R_NAK}, 0, 1'b0);
      frame(4'b1000, $urandom, '0, {5{R_NAK}}, 0, 1'b0);
      frame(4'b0101, $urandom, '0, {8'd0, R_NONE}, 0, 1'b0);
      frame(4'b0110, $urandom, '1, {8'd0, R_ACK}, AW, 1'b0);
      frame(4'b1001, $urandom, '0, {6'd0, R_ACK, R_BOTH}, 1, 1'b0);
      for (int f = 0; f < 30; f++) begin
         rs = '0;
         for (int a = 0; a < 5; a++) begin
            x = $urandom_range(0, 9);
            rs = {rs[7:0], x < 5 ? R_ACK : x < 8 ? R_NAK : x == 8 ? R_BOTH : R_NONE};
         end
         frame(4'($urandom_range(1, 15)), $urandom, 4'($urandom), rs, 0, 1'($urandom));
      end
      req = '0;
      tick();
      chk("end_quiet", {done, err, ack}, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
